bist_sig_ctrl: RTL and testbench



---
 rtl/bist_sig_ctrl_if.sv | 37 +++
 rtl/bist_sig_ctrl.sv | 127 ++++++++++++
 tb/tb_bist_sig_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/bist_sig_ctrl_if.sv
//------------------------------------------------------------------------------
// bist_sig_ctrl_if : control and signature-register bundle for bist_sig_ctrl
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bist_sig_ctrl_if #(
  parameter int SIG_WIDTH = 4,
  parameter int CNT_WIDTH = 16
);
  logic                 start;
  logic [CNT_WIDTH-1:0] run_len;
  logic [SIG_WIDTH-1:0] golden;
  logic [SIG_WIDTH-1:0] seed;
  logic                 sig_sgo;
  logic                 sig_reset;
  logic                 sig_sge;
  logic                 sig_sgi;
  logic                 sig_sck;
  logic                 pat_en;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [SIG_WIDTH-1:0] signature;

  modport master (
    output start, run_len, golden, seed, sig_sgo,
    input  sig_reset, sig_sge, sig_sgi, sig_sck, pat_en, busy, done, pass, signature
  );

  modport slave (
    input  start, run_len, golden, seed, sig_sgo,
    output sig_reset, sig_sge, sig_sgi, sig_sck, pat_en, busy, done, pass, signature
  );
endinterface

`default_nettype wire

// File: rtl/bist_sig_ctrl.sv
//------------------------------------------------------------------------------
// bist_sig_ctrl : MISR sequencer - clear, optional serial seed (SEED_LOAD_EN),
//                 compaction run, MSB-first unload and golden compare.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bist_sig_ctrl #(
  parameter int SIG_WIDTH = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic          Clk,
  input  logic          reset,
  bist_sig_ctrl_if.slave bus
);

  localparam int c_bit_w = $clog2(SIG_WIDTH) + 1;
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(SIG_WIDTH - 1);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_clear  = 3'd1;
  localparam logic [2:0] c_st_seed   = 3'd2;
  localparam logic [2:0] c_st_run    = 3'd3;
  localparam logic [2:0] c_st_unload = 3'd4;
  localparam logic [2:0] c_st_done   = 3'd5;

  logic [2:0]           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [c_bit_w-1:0]   r_bit;
  logic [SIG_WIDTH-1:0] r_golden;
  logic [SIG_WIDTH-1:0] r_signature;
  logic                 r_done;
  logic                 r_pass;

`ifdef SEED_LOAD_EN
  logic [SIG_WIDTH-1:0] r_seed;
  assign bus.sig_sgi = (r_state == c_st_seed) & r_seed[SIG_WIDTH-1];
`else
  logic w_seed_unused;
  assign w_seed_unused = ^bus.seed;
  assign bus.sig_sgi   = 1'b0;
`endif

  // Register-side controls are pure decodes of the registered state
  assign bus.sig_reset = (r_state == c_st_clear);
  assign bus.sig_sge   = (r_state == c_st_run);
  assign bus.sig_sck   = (r_state == c_st_run);
  assign bus.pat_en    = (r_state == c_st_run);
  assign bus.busy      = (r_state == c_st_clear) | (r_state == c_st_seed) |
                         (r_state == c_st_run)   | (r_state == c_st_unload);
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.signature = r_signature;

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state     <= c_st_idle;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_golden    <= '0;
      r_signature <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
`ifdef SEED_LOAD_EN
      r_seed      <= '0;
`endif
    end else begin
      case (r_state)
        c_st_idle: begin
          if (bus.start) begin
            r_cnt    <= bus.run_len;
            r_golden <= bus.golden;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_state  <= c_st_clear;
`ifdef SEED_LOAD_EN
            r_seed   <= bus.seed;
`endif
          end
        end
        c_st_clear: begin
          r_bit <= c_bit_last;
`ifdef SEED_LOAD_EN
          r_state <= c_st_seed;
`else
          r_state <= (r_cnt == '0) ? c_st_unload : c_st_run;
`endif
        end
`ifdef SEED_LOAD_EN
        c_st_seed: begin
          r_seed <= r_seed << 1;
          if (r_bit == '0) begin
            r_bit   <= c_bit_last;
            r_state <= (r_cnt == '0) ? c_st_unload : c_st_run;
          end else begin
            r_bit <= r_bit - c_bit_w'(1);
          end
        end
`endif
        c_st_run: begin
          r_cnt <= r_cnt - CNT_WIDTH'(1);
          if (r_cnt == CNT_WIDTH'(1)) begin
            r_state <= c_st_unload;
          end
        end
        c_st_unload: begin
          // First bit out is the register's last stage, so it ends up as MSB
          r_signature <= {r_signature[SIG_WIDTH-2:0], bus.sig_sgo};
          if (r_bit == '0) begin
            r_state <= c_st_done;
          end else begin
            r_bit <= r_bit - c_bit_w'(1);
          end
        end
        c_st_done: begin
          r_done  <= 1'b1;
          r_pass  <= (r_signature == r_golden);
          r_state <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bist_sig_ctrl.sv
//------------------------------------------------------------------------------
// tb_bist_sig_ctrl : directed bench with an attached behavioural MISR and a
//                    scoreboard of expected signature/pass/latency per run.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bist_sig_ctrl;

  localparam int SW = 4;
  localparam int CW = 16;
`ifdef SEED_LOAD_EN
  localparam int c_seed_lat = SW;
  localparam bit c_seed_on  = 1'b1;
`else
  localparam int c_seed_lat = 0;
  localparam bit c_seed_on  = 1'b0;
`endif

  typedef struct {
    logic [SW-1:0] sig;
    logic          pass;
    int            lat;
    int            sck;
  } exp_t;

  logic Clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   sck_cnt = 0;
  int   runs = 0;
  int   both_cnt = 0;
  exp_t sb[$];
  logic sgi_hist [0:15];

  logic [7:0]    pat_stream = 8'b1011_0010;
  logic [SW-1:0] m_reg = '0;
  int            m_pidx = 0;
  logic          prev_rst = 1'b0;

  bist_sig_ctrl_if #(.SIG_WIDTH(SW), .CNT_WIDTH(CW)) bus ();

  bist_sig_ctrl #(.SIG_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // x^4 + x + 1 MISR, stage 0 takes the pattern bit
  function automatic logic [SW-1:0] misr_step(input logic [SW-1:0] r, input logic d);
    return {r[2], r[1], r[0] ^ r[3], r[3] ^ d};
  endfunction

  function automatic logic [SW-1:0] misr_calc(input int len, input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s;
    for (int i = 0; i < len; i++) r = misr_step(r, pat_stream[7 - (i % 8)]);
    return r;
  endfunction

  assign bus.sig_sgo = m_reg[SW-1];

  always @(posedge Clk) begin
    if (bus.sig_reset) begin
      m_reg  <= '0;
      m_pidx <= 0;
    end else if (bus.sig_sge) begin
      if (bus.sig_sck) begin
        m_reg  <= misr_step(m_reg, bus.pat_en ? pat_stream[7 - (m_pidx % 8)] : 1'b0);
        m_pidx <= m_pidx + 1;
      end
    end else begin
      m_reg <= {m_reg[SW-2:0], bus.sig_sgi};
    end
  end

  always @(posedge Clk) begin
    cyc++;
    if (bus.sig_sck) sck_cnt++;
    if (bus.sig_reset && !prev_rst) runs++;
    if (bus.done && bus.busy) both_cnt++;
    prev_rst = bus.sig_reset;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_run(input int rl, input logic [SW-1:0] gold, input logic [SW-1:0] sd,
                        input bit hold_start, input string tag);
    exp_t e;
    int   n0, sck0, runs0;
    e.sig  = misr_calc(rl, c_seed_on ? sd : '0);
    e.pass = (e.sig == gold);
    e.lat  = 2 + rl + SW + c_seed_lat;
    e.sck  = rl;
    sb.push_back(e);
    bus.start   = 1'b1;
    bus.run_len = CW'(rl);
    bus.golden  = gold;
    bus.seed    = sd;
    sck0  = sck_cnt;
    runs0 = runs;
    tick();
    n0 = cyc;
    chk({tag, " done_clr"}, {31'd0, bus.done}, 32'd0);
    if (hold_start) begin
      bus.golden  = ~gold;
      bus.run_len = CW'(rl + 3);
      bus.seed    = ~sd;
    end else begin
      bus.start = 1'b0;
    end
    while (bus.done !== 1'b1 && (cyc - n0) < 300) begin
      tick();
      if ((cyc - n0) < 16) sgi_hist[cyc - n0] = bus.sig_sgi;
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    chk({tag, " latency"}, cyc - n0, e.lat);
    chk({tag, " signature"}, {28'd0, bus.signature}, {28'd0, e.sig});
    chk({tag, " pass"}, {31'd0, bus.pass}, {31'd0, e.pass});
    chk({tag, " sck_cycles"}, sck_cnt - sck0, e.sck);
    chk({tag, " runs"}, runs - runs0, 1);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.run_len = '0;
    bus.golden  = '0;
    bus.seed    = '0;
    repeat (2) tick();
    reset = 1'b0;

    // Idle after reset: every output stays low
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outputs",
          {19'd0, bus.sig_reset, bus.sig_sge, bus.sig_sgi, bus.sig_sck, bus.pat_en,
           bus.busy, bus.done, bus.pass, bus.signature}, 32'd0);
    end

    // Abort a long run with reset
    bus.start = 1'b1; bus.run_len = CW'(100); bus.golden = 4'h5;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    chk("midrun_busy_before", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_sge", {31'd0, bus.sig_sge}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    tick();

    do_run(0, 4'h0, 4'h0, 1'b0, "rl0");
    do_run(8, misr_calc(8, 4'h0), 4'h0, 1'b0, "rl8_good");
    do_run(8, misr_calc(8, 4'h0) ^ 4'h1, 4'h0, 1'b0, "rl8_bad");
    do_run(5, misr_calc(5, 4'h0), 4'h0, 1'b1, "rl5_hold_start");

    repeat (3) tick();
    chk("done_held", {31'd0, bus.done}, 32'd1);
    chk("idle_after_done", {31'd0, bus.busy}, 32'd0);

`ifdef SEED_LOAD_EN
    begin
      logic [SW-1:0] seedv;
      seedv = 4'hA;
      do_run(0, seedv, seedv, 1'b0, "seed_a");
      for (int k = 1; k <= SW; k++)
        chk("seed_sgi", {31'd0, sgi_hist[k]}, {31'd0, seedv[SW - k]});
    end
`endif

    chk("done_busy_overlap", both_cnt, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
